// File: rtl/rdq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rdq_pkg
// Description : Shared FSM state encoding and header constants for rdq_drain.
// Revision    : 1.0 - initial release
// ============================================================================
package rdq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_CHECK = 3'd2,
        ST_FETCH = 3'd3,
        ST_LOAD  = 3'd4,
        ST_SEND  = 3'd5,
        ST_DONE  = 3'd6
    } rdq_state_e;

    localparam logic [7:0] RDQ_HDR_MARKER = 8'hA5;
    localparam int         RDQ_SEQ_WIDTH  = 8;

    // Top 24 bits of a header word: marker, app byte, sequence byte.
    function automatic logic [23:0] rdq_hdr_prefix(input logic [7:0] app_byte,
                                                   input logic [7:0] seq_byte);
        return {RDQ_HDR_MARKER, app_byte, seq_byte};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rdq_seq_bank.sv
`default_nettype none
// ============================================================================
// Module      : rdq_seq_bank
// Description : Per-application 8-bit header sequence counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rdq_seq_bank
    import rdq_pkg::*;
#(
    parameter int TOTAL_APPS   = 8,
    parameter int APP_ID_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic [APP_ID_WIDTH-1:0]  inc_app,
    input  logic [APP_ID_WIDTH-1:0]  rd_app,
    output logic [RDQ_SEQ_WIDTH-1:0] rd_seq
);

    logic [TOTAL_APPS-1:0][RDQ_SEQ_WIDTH-1:0] r_seq;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seq <= '0;
        end else begin
            for (int i = 0; i < TOTAL_APPS; i++) begin
                if (inc && (inc_app == APP_ID_WIDTH'(i))) begin
                    r_seq[i] <= r_seq[i] + RDQ_SEQ_WIDTH'(1);
                end
            end
        end
    end

    assign rd_seq = r_seq[rd_app];

endmodule
`default_nettype wire

// File: rtl/rdq_drain.sv
`default_nettype none
// ============================================================================
// Module      : rdq_drain
// Description : Per-grant burst drain from per-app FIFOs onto a framed stream.
//               Optional header word per grant when RDQ_HEADER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rdq_drain
    import rdq_pkg::*;
#(
    parameter int TOTAL_APPS   = 8,
    parameter int APP_ID_WIDTH = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             read_queue,
    input  logic [APP_ID_WIDTH-1:0]          app_id,
    output logic                             read_done,
    input  logic [TOTAL_APPS-1:0]            data_queue_empty,
    output logic [TOTAL_APPS-1:0]            data_queue_rd_en,
    input  logic [TOTAL_APPS*DATA_WIDTH-1:0] data_queue_dout,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic [APP_ID_WIDTH-1:0]          out_app_id
);

    localparam int                     c_cnt_width = $clog2(MAX_BURST + 1);
    localparam logic [c_cnt_width-1:0] c_last_cnt  = c_cnt_width'(MAX_BURST - 1);
    localparam logic [c_cnt_width-1:0] c_max_cnt   = c_cnt_width'(MAX_BURST);

    rdq_state_e                r_state;
    rdq_state_e                w_state_nxt;
    logic [c_cnt_width-1:0]    r_count;
    logic [APP_ID_WIDTH-1:0]   r_app;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_last;
    logic [TOTAL_APPS-1:0]     w_rd_en;
    logic                      w_sel_empty;
    logic [DATA_WIDTH-1:0]     w_sel_dout;
    logic                      w_fire;

    assign w_sel_empty = data_queue_empty[r_app];
    assign w_sel_dout  = data_queue_dout[int'(r_app)*DATA_WIDTH +: DATA_WIDTH];
    assign w_fire      = out_valid && out_ready;

`ifdef RDQ_HEADER_EN
    logic [RDQ_SEQ_WIDTH-1:0] w_seq_grant;
    logic                     w_seq_inc;
    logic [DATA_WIDTH-1:0]    w_hdr_word;

    assign w_seq_inc = (r_state == ST_HDR) && w_fire;

    rdq_seq_bank #(
        .TOTAL_APPS   (TOTAL_APPS),
        .APP_ID_WIDTH (APP_ID_WIDTH)
    ) u_seq_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_seq_inc),
        .inc_app (r_app),
        .rd_app  (app_id),
        .rd_seq  (w_seq_grant)
    );

    // Header is built from the incoming grant so it is already stable in HDR.
    always_comb begin
        w_hdr_word = '0;
        w_hdr_word[DATA_WIDTH-1 -: 24] = rdq_hdr_prefix(8'(app_id), w_seq_grant);
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = '0;
        case (r_state)
            ST_IDLE: begin
                if (read_queue) begin
`ifdef RDQ_HEADER_EN
                    w_state_nxt = ST_HDR;
`else
                    w_state_nxt = ST_CHECK;
`endif
                end
            end
`ifdef RDQ_HEADER_EN
            ST_HDR: begin
                if (out_ready) begin
                    w_state_nxt = r_last ? ST_DONE : ST_CHECK;
                end
            end
`endif
            ST_CHECK: begin
                w_state_nxt = w_sel_empty ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                // Defensive: never pop an empty FIFO or beyond the burst cap.
                if (w_sel_empty || (r_count >= c_max_cnt)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_rd_en[r_app] = 1'b1;
                    w_state_nxt    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    w_state_nxt = r_last ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_app   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (read_queue) begin
                        r_app   <= app_id;
                        r_count <= '0;
`ifdef RDQ_HEADER_EN
                        r_data  <= w_hdr_word;
                        r_last  <= data_queue_empty[app_id];
`else
                        r_last  <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    // Empty here already reflects the pop issued in FETCH.
                    r_data  <= w_sel_dout;
                    r_count <= r_count + c_cnt_width'(1);
                    r_last  <= (r_count == c_last_cnt) || w_sel_empty;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RDQ_HEADER_EN
    assign out_valid = (r_state == ST_SEND) || (r_state == ST_HDR);
`else
    assign out_valid = (r_state == ST_SEND);
`endif
    assign read_done        = (r_state == ST_DONE);
    assign data_queue_rd_en = w_rd_en;
    assign out_data         = r_data;
    assign out_last         = r_last;
    assign out_app_id       = r_app;

endmodule
`default_nettype wire
